ddr_port_arbiter: RTL

- Shares one MIG user port command channel between two requesters.
  - The display-fetch reader issues READ bursts.
  - The Mandelbrot pixel writer issues WRITE bursts.
- Sits between those requesters and the MIG port's cmd_* signals. The requesters no longer drive cmd_en directly.
- Policy: round-robin, with an urgent-read override. A write is only eligible once its burst data is already in the port write FIFO.

---
 rtl/ddr_arb_pkg.sv | 11 +
 rtl/arb_pick.sv | 33 +++
 rtl/ddr_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the two-requester MIG command port arbiter.
package ddr_arb_pkg;

  localparam logic [2:0] INSTR_RD = 3'b001;
  localparam logic [2:0] INSTR_WR = 3'b000;

  typedef enum logic [1:0] {WAIT_CALIB, IDLE, ISSUE, GAP} state_t;

  typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} grant_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the display reader and the pixel writer.
module arb_pick
  import ddr_arb_pkg::*;
(
  input  logic   rd_elig,
  input  logic   wr_elig,
  input  logic   rd_urgent,
  input  logic   rd_starve,
  input  logic   wr_starve,
  input  grant_t last_grant,
  output logic   valid,
  output grant_t grant
);

  // Starvation overrides urgency, urgency overrides plain round-robin.
  always_comb begin
    valid = rd_elig || wr_elig;
    grant = GNT_RD;
    if (rd_elig && wr_elig) begin
      if (rd_starve)
        grant = GNT_RD;
      else if (wr_starve)
        grant = GNT_WR;
      else if (rd_urgent)
        grant = GNT_RD;
      else
        grant = (last_grant == GNT_RD) ? GNT_WR : GNT_RD;
    end else if (wr_elig) begin
      grant = GNT_WR;
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one MIG command channel between a read and a write requester.
// Optional starvation limiting is enabled with `define ARB_STARVE_LIMIT_EN.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int BL_W     = 6,
  parameter int CNT_W    = 7,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic              rd_req,
  input  logic              rd_urgent,
  input  logic [BL_W-1:0]   rd_bl,
  input  logic [ADDR_W-1:0] rd_byte_addr,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [BL_W-1:0]   wr_bl,
  input  logic [ADDR_W-1:0] wr_byte_addr,
  input  logic [CNT_W-1:0]  wr_count,
  output logic              wr_ack,
  input  logic              cmd_full,
  output logic [2:0]        cmd_instr,
  output logic [BL_W-1:0]   cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  output logic              cmd_en,
  output logic              last_grant,
  output logic              busy
);

  logic       calib_meta, calib_sync;
  state_t     state, state_next;
  grant_t     grant_q, pick_grant;
  logic       pick_valid, issue_ok;
  logic       rd_elig, wr_elig, rd_starve, wr_starve;
  logic [CNT_W-1:0] wr_need;

  always_ff @(posedge clk) begin
    if (reset) begin
      calib_meta <= 1'b0;
      calib_sync <= 1'b0;
    end else begin
      calib_meta <= mem_calib_done;
      calib_sync <= calib_meta;
    end
  end

  // A write only competes once its whole burst already sits in the write FIFO.
  assign wr_need = CNT_W'(wr_bl) + CNT_W'(1);
  assign rd_elig = rd_req;
  assign wr_elig = wr_req && (wr_count >= wr_need);

`ifdef ARB_STARVE_LIMIT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  logic [WAIT_W-1:0] rd_wait, wr_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wait <= '0;
      wr_wait <= '0;
    end else begin
      if (!rd_elig || (state == ISSUE && grant_q == GNT_RD) ||
          (state == IDLE && issue_ok && pick_grant == GNT_RD))
        rd_wait <= '0;
      else if (rd_wait != WAIT_W'(MAX_WAIT))
        rd_wait <= rd_wait + WAIT_W'(1);
      if (!wr_elig || (state == ISSUE && grant_q == GNT_WR) ||
          (state == IDLE && issue_ok && pick_grant == GNT_WR))
        wr_wait <= '0;
      else if (wr_wait != WAIT_W'(MAX_WAIT))
        wr_wait <= wr_wait + WAIT_W'(1);
    end
  end

  assign rd_starve = (rd_wait == WAIT_W'(MAX_WAIT));
  assign wr_starve = (wr_wait == WAIT_W'(MAX_WAIT));
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
  assign rd_starve = 1'b0;
  assign wr_starve = 1'b0;
`endif

  arb_pick u_pick (
    .rd_elig    (rd_elig),
    .wr_elig    (wr_elig),
    .rd_urgent  (rd_urgent),
    .rd_starve  (rd_starve),
    .wr_starve  (wr_starve),
    .last_grant (grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  assign issue_ok = calib_sync && !cmd_full && pick_valid;

  always_ff @(posedge clk) begin
    if (reset)
      state <= WAIT_CALIB;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_CALIB: if (calib_sync) state_next = IDLE;
      IDLE: begin
        if (!calib_sync)
          state_next = WAIT_CALIB;
        else if (issue_ok)
          state_next = ISSUE;
      end
      ISSUE:   state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = WAIT_CALIB;
    endcase
  end

  // Command fields are captured on the grant decision and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_instr     <= '0;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
      grant_q       <= GNT_WR;
    end else if (state == IDLE && calib_sync && issue_ok) begin
      grant_q <= pick_grant;
      if (pick_grant == GNT_RD) begin
        cmd_instr     <= INSTR_RD;
        cmd_bl        <= rd_bl;
        cmd_byte_addr <= {rd_byte_addr[ADDR_W-1:2], 2'b00};
      end else begin
        cmd_instr     <= INSTR_WR;
        cmd_bl        <= wr_bl;
        cmd_byte_addr <= {wr_byte_addr[ADDR_W-1:2], 2'b00};
      end
    end
  end

  always_comb begin
    cmd_en     = (state == ISSUE);
    rd_ack     = (state == ISSUE) && (grant_q == GNT_RD);
    wr_ack     = (state == ISSUE) && (grant_q == GNT_WR);
    busy       = (state != IDLE);
    last_grant = grant_q;
  end

endmodule
